// File: rtl/hs32_sram_pkg.sv
// Shared types and constants for the HS32 SRAM port-0 arbiter.
// Used by the top-level arbiter and its round-robin picker.
package hs32_sram_pkg;

  localparam int SRAM_DW = 32;
  localparam int SRAM_MW = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

  typedef enum logic {
    GNT_CPU = 1'b0,
    GNT_WB  = 1'b1
  } grant_t;

  // Reads always present a full mask to the macro; writes use the requester's byte enables.
  function automatic logic [SRAM_MW-1:0] pin_mask(input logic we, input logic [SRAM_MW-1:0] mask);
    return we ? mask : {SRAM_MW{1'b1}};
  endfunction

endpackage

// File: rtl/hs32_rr_arb2.sv
// Two-requester picker: round-robin on ties, or Wishbone-first when prio_wb is set.
// Holds the last grant so a waiting requester is never passed over twice.
module hs32_rr_arb2
  import hs32_sram_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   req_cpu,
  input  logic   req_wb,
  input  logic   prio_wb,
  input  logic   update,
  output logic   valid,
  output grant_t winner
);

  grant_t last_grant_reg;

  always_comb begin
    valid  = req_cpu | req_wb;
    winner = GNT_WB;
    if (req_cpu && req_wb) begin
      if (prio_wb || (last_grant_reg == GNT_CPU)) begin
        winner = GNT_WB;
      end else begin
        winner = GNT_CPU;
      end
    end else if (req_cpu) begin
      winner = GNT_CPU;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_reg <= GNT_WB;
    end else if (update && valid) begin
      last_grant_reg <= winner;
    end
  end

endmodule

// File: rtl/hs32_sram_arbiter.sv
// Shares one SRAM macro 1RW port between the HS32 CPU bank port and a Wishbone slave.
// Fixed four-cycle transaction: IDLE -> ACCESS -> WAIT -> RESP, macro pins registered.
module hs32_sram_arbiter
  import hs32_sram_pkg::*;
#(
  parameter int          ADDR_W    = 8,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_ni,
  input  logic                 prio_wb,
  input  logic                 cpu_req,
  input  logic                 cpu_we,
  input  logic [SRAM_MW-1:0]   cpu_mask,
  input  logic [ADDR_W-1:0]    cpu_addr,
  input  logic [SRAM_DW-1:0]   cpu_wdata,
  output logic                 cpu_ack,
  output logic [SRAM_DW-1:0]   cpu_rdata,
  input  logic                 wbs_cyc_i,
  input  logic                 wbs_stb_i,
  input  logic                 wbs_we_i,
  input  logic [SRAM_MW-1:0]   wbs_sel_i,
  input  logic [31:0]          wbs_adr_i,
  input  logic [SRAM_DW-1:0]   wbs_dat_i,
  output logic                 wbs_ack_o,
  output logic [SRAM_DW-1:0]   wbs_dat_o,
  output logic                 sram_csb,
  output logic                 sram_web,
  output logic [SRAM_MW-1:0]   sram_wmask,
  output logic [ADDR_W-1:0]    sram_addr,
  output logic [SRAM_DW-1:0]   sram_din,
  input  logic [SRAM_DW-1:0]   sram_dout
);

  state_t               state_reg, state_next;
  grant_t               grant_reg;
  logic                 abort_reg;
  logic                 we_reg;
  logic                 sram_csb_reg;
  logic                 sram_web_reg;
  logic [SRAM_MW-1:0]   sram_wmask_reg;
  logic [ADDR_W-1:0]    sram_addr_reg;
  logic [SRAM_DW-1:0]   sram_din_reg;
  logic [SRAM_DW-1:0]   cpu_rdata_reg;
  logic [SRAM_DW-1:0]   wb_rdata_reg;
  logic [SRAM_DW-1:0]   rdata_next;

  logic                 wb_req;
  logic                 wb_hit;
  logic                 arb_valid;
  grant_t               arb_winner;
  logic                 pick_wb;
  logic                 owner_req;
  logic                 sel_we;
  logic [ADDR_W-1:0]    sel_addr;
  logic [SRAM_MW-1:0]   sel_mask;
  logic [SRAM_DW-1:0]   sel_wdata;
  logic                 unused_adr_lsb;

  assign wb_req         = wbs_cyc_i & wbs_stb_i;
  assign wb_hit         = wb_req & (wbs_adr_i[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]);
  assign unused_adr_lsb = &{1'b0, wbs_adr_i[1:0]};

  hs32_rr_arb2 u_arb (
    .clk     (wb_clk_i),
    .rst_n   (wb_rst_ni),
    .req_cpu (cpu_req),
    .req_wb  (wb_hit),
    .prio_wb (prio_wb),
    .update  (state_reg == IDLE),
    .valid   (arb_valid),
    .winner  (arb_winner)
  );

  assign pick_wb  = (arb_winner == GNT_WB);
  assign sel_we   = pick_wb ? wbs_we_i : cpu_we;
  assign sel_addr = pick_wb ? wbs_adr_i[ADDR_W+1:2] : cpu_addr;

  // Per-byte-lane steering of mask and write data from the winning requester.
  generate
    for (genvar gi = 0; gi < SRAM_MW; gi++) begin : g_lane
      assign sel_mask[gi]         = pick_wb ? wbs_sel_i[gi] : cpu_mask[gi];
      assign sel_wdata[8*gi +: 8] = pick_wb ? wbs_dat_i[8*gi +: 8] : cpu_wdata[8*gi +: 8];
    end
  endgenerate

  // A granted requester that lets go before RESP still gets its macro cycle, just no ack.
  assign owner_req  = (grant_reg == GNT_CPU) ? cpu_req : wb_req;
  assign rdata_next = we_reg ? '0 : sram_dout;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (arb_valid) state_next = ACCESS;
      ACCESS:  state_next = WAIT;
      WAIT:    state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_reg      <= IDLE;
      grant_reg      <= GNT_WB;
      abort_reg      <= 1'b0;
      we_reg         <= 1'b0;
      sram_csb_reg   <= 1'b1;
      sram_web_reg   <= 1'b1;
      sram_wmask_reg <= '0;
      sram_addr_reg  <= '0;
      sram_din_reg   <= '0;
      cpu_rdata_reg  <= '0;
      wb_rdata_reg   <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (arb_valid) begin
            grant_reg      <= arb_winner;
            abort_reg      <= 1'b0;
            we_reg         <= sel_we;
            sram_csb_reg   <= 1'b0;
            sram_web_reg   <= ~sel_we;
            sram_wmask_reg <= pin_mask(sel_we, sel_mask);
            sram_addr_reg  <= sel_addr;
            sram_din_reg   <= sel_wdata;
          end
        end
        ACCESS: begin
          sram_csb_reg <= 1'b1;
          sram_web_reg <= 1'b1;
          if (!owner_req) abort_reg <= 1'b1;
        end
        WAIT: begin
          if (!owner_req) abort_reg <= 1'b1;
          if (grant_reg == GNT_CPU) begin
            cpu_rdata_reg <= rdata_next;
          end else begin
            wb_rdata_reg <= rdata_next;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign cpu_ack    = (state_reg == RESP) && (grant_reg == GNT_CPU) && cpu_req && !abort_reg;
  assign wbs_ack_o  = (state_reg == RESP) && (grant_reg == GNT_WB) && wb_req && !abort_reg;
  assign cpu_rdata  = cpu_rdata_reg;
  assign wbs_dat_o  = wb_rdata_reg;
  assign sram_csb   = sram_csb_reg;
  assign sram_web   = sram_web_reg;
  assign sram_wmask = sram_wmask_reg;
  assign sram_addr  = sram_addr_reg;
  assign sram_din   = sram_din_reg;

endmodule
